// File: rtl/me_frame_sequencer.sv
// Frame-level macroblock scheduler for the hexbs_top motion-estimation engine.
// Sweeps one frame in raster order, queues per-MB results and accumulates frame SAD.
module me_frame_sequencer #(
  parameter int FRAME_WIDTH  = 352,
  parameter int FRAME_HEIGHT = 240,
  parameter int MB_SIZE      = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       frame_start_addr,
  output logic              busy,
  output logic              frame_done,
  output logic              error,
  output logic [31:0]       sad_total,
  output logic              me_start,
  output logic [31:0]       me_frame_start_addr,
  output logic [31:0]       me_mb_x,
  output logic [31:0]       me_mb_y,
  input  logic              me_done,
  input  logic signed [5:0] me_mv_x,
  input  logic signed [5:0] me_mv_y,
  input  logic [15:0]       me_sad,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_mb_x,
  output logic [31:0]       res_mb_y,
  output logic signed [5:0] res_mv_x,
  output logic signed [5:0] res_mv_y,
  output logic [15:0]       res_sad,
  output logic              res_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] LAST_X   = 32'(FRAME_WIDTH - MB_SIZE);
  localparam logic [31:0] LAST_Y   = 32'(FRAME_HEIGHT - MB_SIZE);
  localparam logic [31:0] MB_STEP  = 32'(MB_SIZE);
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_e;

  typedef struct packed {
    logic [31:0]       x;
    logic [31:0]       y;
    logic signed [5:0] mvX;
    logic signed [5:0] mvY;
    logic [15:0]       sad;
    logic              last;
  } entry_t;

  state_e state_q, state_d;

  logic [31:0] addr_q, addr_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] sad_q, sad_d;
  logic        err_q, err_d;
  logic [31:0] wd_q, wd_d;

  entry_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;

  logic   lastMb, spaceAvail, acceptStart, aborting;
  logic   doPush, doPop, timedOut, flush;
  entry_t pushEntry, headEntry;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Abort outranks both me_done and the watchdog; me_done outranks the watchdog.
  assign lastMb      = (x_q == LAST_X) && (y_q == LAST_Y);
  assign spaceAvail  = count_q < CW'(FIFO_DEPTH);
  assign acceptStart = (state_q == IDLE) && start;
  assign aborting    = abort && (state_q != IDLE);
  assign doPush      = (state_q == WAIT) && me_done && !aborting;
  assign timedOut    = (state_q == WAIT) && !me_done && !aborting && (wd_q == WD_LIMIT);
  assign doPop       = res_valid && res_ready;
  assign flush       = aborting || timedOut;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (aborting) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (start) state_d = ISSUE;
        ISSUE:  if (spaceAvail) state_d = WAIT;
        WAIT: begin
          if (me_done)       state_d = lastMb ? FINISH : ISSUE;
          else if (timedOut) state_d = IDLE;
        end
        FINISH: if (count_q == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    me_start   = (state_q == ISSUE) && spaceAvail;
    busy       = (state_q != IDLE);
    frame_done = (state_q == FINISH) && (count_q == '0) && !abort;
  end

  always_comb begin
    addr_d = addr_q;
    x_d    = x_q;
    y_d    = y_q;
    sad_d  = sad_q;
    err_d  = err_q;
    wd_d   = wd_q;
    if (acceptStart) begin
      addr_d = frame_start_addr;
      x_d    = '0;
      y_d    = '0;
      sad_d  = '0;
      err_d  = 1'b0;
      wd_d   = '0;
    end else begin
      if (me_start) begin
        wd_d = '0;
      end else if (state_q == WAIT) begin
        wd_d = wd_q + 32'd1;
      end
      if (doPush) begin
        sad_d = sad_q + {16'd0, me_sad};
        if (x_q == LAST_X) begin
          x_d = '0;
          y_d = y_q + MB_STEP;
        end else begin
          x_d = x_q + MB_STEP;
        end
      end
      if (timedOut) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      sad_q  <= '0;
      err_q  <= 1'b0;
      wd_q   <= '0;
    end else begin
      addr_q <= addr_d;
      x_q    <= x_d;
      y_q    <= y_d;
      sad_q  <= sad_d;
      err_q  <= err_d;
      wd_q   <= wd_d;
    end
  end

  assign pushEntry = '{x: x_q, y: y_q, mvX: me_mv_x, mvY: me_mv_y, sad: me_sad, last: lastMb};

  // Only one search is outstanding and ISSUE waits for space, so a push never overflows.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = nextPtr(wrPtr_q);
      if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
      if (doPush && !doPop) begin
        count_d = count_q + CW'(1);
      end else if (!doPush && doPop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (doPush) mem_q[wrPtr_q] <= pushEntry;
    end
  end

  assign headEntry = mem_q[rdPtr_q];

  assign res_valid           = (count_q != '0);
  assign res_mb_x            = headEntry.x;
  assign res_mb_y            = headEntry.y;
  assign res_mv_x            = headEntry.mvX;
  assign res_mv_y            = headEntry.mvY;
  assign res_sad             = headEntry.sad;
  assign res_last            = headEntry.last;
  assign error               = err_q;
  assign sad_total           = sad_q;
  assign me_frame_start_addr = addr_q;
  assign me_mb_x             = x_q;
  assign me_mb_y             = y_q;

endmodule

// File: doc/me_frame_sequencer.md
# me_frame_sequencer

Frame-level macroblock scheduler that sits in front of the `hexbs_top` motion-estimation engine. It sweeps every macroblock of one frame in raster order and issues one engine search per MB. Results go into a parametrised FIFO and out on a valid/ready stream, while the block accumulates the frame SAD. It replaces the per-MB start/done driving currently done by hand, and adds backpressure, a per-MB timeout, and abort.

## Interface
- `FRAME_WIDTH`, 352, frame width in pixels; must be a multiple of `MB_SIZE`
- `FRAME_HEIGHT`, 240, frame height in pixels; must be a multiple of `MB_SIZE`
- `MB_SIZE`, 16, macroblock edge in pixels
- `FIFO_DEPTH`, 4, result FIFO entries, ≥1
- `TIMEOUT`, 50000, maximum cycles waiting for `me_done` per MB
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `start` in 1: one-cycle request to process a frame; ignored unless idle
- `abort` in 1: cancel current frame
- `frame_start_addr` in 32: base address of current frame; latched on accepted `start`
- `busy` out 1: high from accepted `start` until return to IDLE
- `frame_done` out 1: one-cycle pulse; whole frame delivered
- `error` out 1: sticky timeout flag; cleared by next accepted `start`
- `sad_total` out 32: sum of all MB SADs of the frame; wraps mod 2^32
- `me_start` out 1: engine start pulse
- `me_frame_start_addr` out 32: latched base address
- `me_mb_x`, `me_mb_y` out 32: MB pixel coordinates, not MB indices
- `me_done` in 1: engine completion
- `me_mv_x`, `me_mv_y` in 6 signed: engine MV; `me_sad` in 16: engine SAD
- `res_valid` out 1, `res_ready` in 1: result stream handshake
- `res_mb_x`, `res_mb_y` out 32; `res_mv_x`, `res_mv_y` out 6 signed; `res_sad` out 16; `res_last` out 1: high on the frame's final MB entry

## Operation
- States: IDLE, ISSUE, WAIT, FINISH.
- **IDLE**
  - `start` latches `frame_start_addr`, zeroes x/y, `sad_total`, `error` and the watchdog.
  - Then moves to ISSUE.
- **ISSUE**
  - `me_start` = (state==ISSUE) && (fifo_count < `FIFO_DEPTH`).
  - When `me_start` is high, clears the watchdog and moves to WAIT.
  - Otherwise stalls in ISSUE.
- **WAIT**
  - `me_mb_x`/`me_mb_y` are held.
  - On `me_done`: push {x, y, mv, sad, last} to the FIFO and add `me_sad` to `sad_total`.
  - Then x += `MB_SIZE`. On x == `FRAME_WIDTH`-`MB_SIZE`, x=0 and y += `MB_SIZE`.
  - Moves to FINISH if this was the last MB, else to ISSUE.
  - If the watchdog reaches `TIMEOUT` first: set `error`, flush the FIFO, go to IDLE, no `frame_done`.
- **FINISH**
  - When the FIFO is empty (last entry popped), pulse `frame_done` and go to IDLE.
- Only one search is outstanding at a time. The ISSUE space check guarantees the WAIT push never overflows.
- FIFO push and pop in the same cycle leave the count unchanged.
- `me_done` outside WAIT is ignored.
- `abort` (any non-IDLE state): next state IDLE, FIFO flushed, `res_valid` low, no `frame_done`, `error` unchanged. Abort has priority over `me_done` and timeout in the same cycle.
- MB count = (`FRAME_WIDTH`/`MB_SIZE`)·(`FRAME_HEIGHT`/`MB_SIZE`); the last MB is at (`FRAME_WIDTH`-`MB_SIZE`, `FRAME_HEIGHT`-`MB_SIZE`).

## Timing
- Reset: state IDLE; every output 0, including `me_*` coordinates/address, `sad_total`, `error` and `res_*`; FIFO empty.
- `start` sampled at edge k → `busy` and `me_start` high in cycle k+1 (FIFO empty).
- `me_done` sampled at edge n:
  - entry visible on `res_*` with `res_valid` high from cycle n+1;
  - next `me_start` high in cycle n+1 (one-cycle done→start gap).
- `res_*` are FIFO head, stable while `res_valid && !res_ready`.
- Final pop at edge m → `frame_done` high in cycle m+1, `busy` low from cycle m+2.
- Timeout: `error` is high and `busy` low in the cycle after the watchdog hits `TIMEOUT`.

## Test plan
- **Raster sweep.** `FRAME_WIDTH`=48, `FRAME_HEIGHT`=32, engine model asserts `me_done` 3 cycles after `me_start` with `me_sad`=10·i, `res_ready`=1.
  - 6 results at (0,0),(16,0),(32,0),(0,16),(16,16),(32,16).
  - `res_last` only on the 6th.
  - `sad_total`=150; one `frame_done` pulse.
- **Backpressure.** `FIFO_DEPTH`=4, `res_ready`=0 → exactly 4 `me_start` pulses then stall in ISSUE. Raise `res_ready` → remaining 2 issued, 6 results in order.
- **Timeout.** `TIMEOUT`=100, engine never done → `error`=1 and `busy`=0 one cycle after the 100th wait cycle; no `frame_done`. Next `start` clears `error`.
- **Abort.** `abort` after 2 results popped → IDLE next cycle, `res_valid`=0, no further `me_start`. New `start` restarts at (0,0).
- **Ignored events.** `start` while `busy` is ignored (coordinates unaffected). `rst_n`=0 during WAIT → all outputs 0 next cycle.
- **Default frame.** Default 352×240 parameters → 330 results; last at (336,224) with `res_last`=1; `frame_done` once.
